// File: rtl/alu5_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu5_sequencer_pkg
//  Description : Shared widths, opcodes and FSM encodings for the 5-bit ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu5_sequencer_pkg;

    localparam int OPW       = 5;
    localparam int RW        = 2 * OPW;
    localparam int MUL_ITERS = OPW;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_AND  = 3'b000;
    localparam opcode_t OP_OR   = 3'b001;
    localparam opcode_t OP_XOR  = 3'b010;
    localparam opcode_t OP_NOT  = 3'b011;
    localparam opcode_t OP_ADD  = 3'b100;
    localparam opcode_t OP_SUB  = 3'b101;
    localparam opcode_t OP_MUL  = 3'b110;
    localparam opcode_t OP_RSVD = 3'b111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] MUL_LAST = 3'(MUL_ITERS - 1);

    function automatic logic [RW-1:0] zext(input logic [OPW-1:0] v);
        return {{(RW - OPW){1'b0}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu5_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu5_sequencer_if
//  Description : Operation request / result handshake bundle for the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu5_sequencer_if;
    import alu5_sequencer_pkg::*;

    logic           in_valid;
    logic           in_ready;
    opcode_t        op;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           out_valid;
    logic           out_ready;
    logic [RW-1:0]  result;
    logic           err;
    logic           busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, err, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, err, busy
    );

endinterface
`default_nettype wire

// File: rtl/alu5_mul_shiftadd.sv
`default_nettype none
// ============================================================================
//  Module      : alu5_mul_shiftadd
//  Description : Unsigned shift-add multiplier, one iteration per run cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu5_mul_shiftadd
    import alu5_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  logic           run,
    output logic           done,
    output logic [RW-1:0]  product
);

    logic [RW-1:0] r_acc;
    logic [RW-1:0] r_areg;
    logic [RW-1:0] r_breg;
    logic [2:0]    r_cnt;
    logic [RW-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_breg[0] ? r_areg : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_areg <= '0;
            r_breg <= '0;
            r_cnt  <= '0;
        end else if (start) begin
            r_acc  <= '0;
            r_areg <= zext(a);
            r_breg <= zext(b);
            r_cnt  <= '0;
        end else if (run) begin
            r_acc  <= w_acc_next;
            r_areg <= r_areg << 1;
            r_breg <= r_breg >> 1;
            r_cnt  <= r_cnt + 3'd1;
        end
    end

    // The final product includes the addend of the last iteration, so it is
    // taken from the next-state value rather than the stored accumulator.
    assign done    = run & (r_cnt == MUL_LAST);
    assign product = w_acc_next;

endmodule
`default_nettype wire

// File: rtl/alu5_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu5_sequencer
//  Description : Operand capture, op sequencing and result hold for the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu5_sequencer
    import alu5_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    alu5_sequencer_if.slave bus
);

    logic [1:0]    r_state;
    opcode_t       r_op;
    logic [RW-1:0] r_areg;
    logic [RW-1:0] r_breg;
    logic [RW-1:0] r_result;
    logic          r_err;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_mul_start;
    logic          w_mul_run;
    logic          w_mul_done;
    logic [RW-1:0] w_product;
    logic [RW-1:0] w_and;
    logic [RW-1:0] w_or;
    logic [RW-1:0] w_xor;
    logic [RW-1:0] w_not;
    logic [RW-1:0] w_exec_result;
    logic          w_exec_err;

    assign w_in_ready  = (r_state == IDLE) & rst_n;
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_mul_start = w_accept & (bus.op == OP_MUL);
    assign w_mul_run   = (r_state == MUL);

    for (genvar i = 0; i < RW; i++) begin : g_gate
        assign w_and[i] = r_areg[i] & r_breg[i];
        assign w_or[i]  = r_areg[i] | r_breg[i];
        assign w_xor[i] = r_areg[i] ^ r_breg[i];
        assign w_not[i] = ~r_areg[i];
    end

    always_comb begin
        w_exec_result = '0;
        w_exec_err    = 1'b0;
        case (r_op)
            OP_AND:  w_exec_result = w_and;
            OP_OR:   w_exec_result = w_or;
            OP_XOR:  w_exec_result = w_xor;
            OP_NOT:  w_exec_result = w_not;
            OP_ADD:  w_exec_result = r_areg + r_breg;
            OP_SUB:  w_exec_result = r_areg - r_breg;
            OP_MUL:  w_exec_result = '0;
            default: w_exec_err    = 1'b1;
        endcase
    end

    alu5_mul_shiftadd u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .run     (w_mul_run),
        .done    (w_mul_done),
        .product (w_product)
    );

    // result/err are written only on the way into DONE so they stay frozen
    // for however long the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_AND;
            r_areg   <= '0;
            r_breg   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= bus.op;
                        r_areg  <= zext(bus.a);
                        r_breg  <= zext(bus.b);
                        r_state <= (bus.op == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    r_result <= w_exec_result;
                    r_err    <= w_exec_err;
                    r_state  <= DONE;
                end
                MUL: begin
                    if (w_mul_done) begin
                        r_result <= w_product;
                        r_err    <= 1'b0;
                        r_state  <= DONE;
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state == EXEC) | (r_state == MUL);
    assign bus.result    = r_result;
    assign bus.err       = r_err;

endmodule
`default_nettype wire
